// File: rtl/interconn_priority.sv
`default_nettype none
// ============================================================================
//  Module   : interconn_priority
//  Purpose  : N-port registered crossbar between MVU write ports and MVU memory
//             write ports. Each receiver independently picks a fixed-priority
//             winner among the senders targeting it; outputs register in one cycle.
//  Option   : INTERCONN_PRIORITY_HIGH_FIRST_EN -> highest sender index wins
//             (default build: lowest sender index wins).
//  Revision : 1.0 - initial release
// ============================================================================
module interconn_priority #(
   parameter int N     = 8,
   parameter int W     = 64,
   parameter int BADDR = 15
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [N-1:0]     send_to   [N],
   input  logic [N-1:0]     send_en,
   input  logic [BADDR-1:0] send_addr [N],
   input  logic [W-1:0]     send_word [N],
   output logic [N-1:0]     recv_from [N],
   output logic [N-1:0]     recv_en,
   output logic [BADDR-1:0] recv_addr [N],
   output logic [W-1:0]     recv_word [N]
);

   for (genvar j = 0; j < N; j++) begin : g_rx
      logic [N-1:0]     w_req;
      logic [N-1:0]     w_grant;
      logic             w_found;
      logic [BADDR-1:0] w_addr;
      logic [W-1:0]     w_word;

      logic             r_en;
      logic [N-1:0]     r_from;
      logic [BADDR-1:0] r_addr;
      logic [W-1:0]     r_word;

      always_comb begin
         w_req = '0;
         for (int i = 0; i < N; i++) begin
            w_req[i] = send_en[i] & send_to[i][j];
         end
      end

      // Priority encoder: the first requester met in scan order takes the grant.
      always_comb begin
         w_grant = '0;
         w_found = 1'b0;
`ifdef INTERCONN_PRIORITY_HIGH_FIRST_EN
         for (int i = N - 1; i >= 0; i--) begin
`else
         for (int i = 0; i < N; i++) begin
`endif
            if (w_req[i] && !w_found) begin
               w_grant[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
      end

      // One-hot AND-OR mux keyed by the grant vector.
      always_comb begin
         w_addr = '0;
         w_word = '0;
         for (int i = 0; i < N; i++) begin
            w_addr = w_addr | (send_addr[i] & {BADDR{w_grant[i]}});
            w_word = w_word | (send_word[i] & {W{w_grant[i]}});
         end
      end

      always_ff @(posedge clk or negedge clr_n) begin
         if (!clr_n) begin
            r_en   <= 1'b0;
            r_from <= '0;
            r_addr <= '0;
            r_word <= '0;
         end else begin
            r_en   <= |w_req;
            r_from <= w_grant;
            if (|w_req) begin
               r_addr <= w_addr;
               r_word <= w_word;
            end
         end
      end

      assign recv_en[j]   = r_en;
      assign recv_from[j] = r_from;
      assign recv_addr[j] = r_addr;
      assign recv_word[j] = r_word;
   end

endmodule
`default_nettype wire

// File: tb/tb_interconn_priority.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interconn_priority
//  Purpose  : Self-checking bench for interconn_priority; directed scenarios
//             plus randomized traffic against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_interconn_priority;
   localparam int N     = 8;
   localparam int W     = 64;
   localparam int BADDR = 15;
`ifdef INTERCONN_PRIORITY_HIGH_FIRST_EN
   localparam bit HIGH_FIRST = 1'b1;
`else
   localparam bit HIGH_FIRST = 1'b0;
`endif

   logic             clk;
   logic             clr_n;
   logic [N-1:0]     send_to   [N];
   logic [N-1:0]     send_en;
   logic [BADDR-1:0] send_addr [N];
   logic [W-1:0]     send_word [N];
   logic [N-1:0]     recv_from [N];
   logic [N-1:0]     recv_en;
   logic [BADDR-1:0] recv_addr [N];
   logic [W-1:0]     recv_word [N];

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   // reference model state
   logic [N-1:0]     exp_en;
   logic [N-1:0]     exp_from [N];
   logic [BADDR-1:0] exp_addr [N];
   logic [W-1:0]     exp_word [N];

   interconn_priority #(.N(N), .W(W), .BADDR(BADDR)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .send_to   (send_to),
      .send_en   (send_en),
      .send_addr (send_addr),
      .send_word (send_word),
      .recv_from (recv_from),
      .recv_en   (recv_en),
      .recv_addr (recv_addr),
      .recv_word (recv_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: requester set per receiver as an integer bitmask; the winner is
   // its lowest (or highest) set bit, found arithmetically.
   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int j = 0; j < N; j++) begin
            exp_en[j] = 1'b0; exp_from[j] = '0; exp_addr[j] = '0; exp_word[j] = '0;
         end
      end else begin
         for (int j = 0; j < N; j++) begin
            int v;
            int win;
            v = 0;
            for (int i = 0; i < N; i++)
               if (send_en[i] && send_to[i][j]) v = v + (1 << i);
            exp_from[j] = '0;
            exp_en[j]   = (v != 0);
            if (v != 0) begin
               win = HIGH_FIRST ? ($clog2(v + 1) - 1) : $clog2(v & -v);
               exp_from[j][win] = 1'b1;
               exp_addr[j] = send_addr[win];
               exp_word[j] = send_word[win];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         for (int j = 0; j < N; j++) begin
            check($sformatf("model recv_en[%0d]", j),   64'(recv_en[j]),   64'(exp_en[j]));
            check($sformatf("model recv_from[%0d]", j), 64'(recv_from[j]), 64'(exp_from[j]));
            check($sformatf("model recv_addr[%0d]", j), 64'(recv_addr[j]), 64'(exp_addr[j]));
            check($sformatf("model recv_word[%0d]", j), recv_word[j],      exp_word[j]);
         end
      end
   end

   task automatic idle();
      for (int i = 0; i < N; i++) begin
         send_en[i] = 1'b0; send_to[i] = '0; send_addr[i] = '0; send_word[i] = '0;
      end
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < N; i++) begin
         send_en[i]   = ($urandom_range(0, 2) != 0);
         send_to[i]   = N'($urandom);
         send_addr[i] = BADDR'($urandom);
         send_word[i] = {$urandom, $urandom};
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " recv_en"}, 64'(recv_en), 64'd0);
      for (int j = 0; j < N; j++) begin
         check($sformatf("%s recv_from[%0d]", tag, j), 64'(recv_from[j]), 64'd0);
         check($sformatf("%s recv_addr[%0d]", tag, j), 64'(recv_addr[j]), 64'd0);
         check($sformatf("%s recv_word[%0d]", tag, j), recv_word[j], 64'd0);
      end
   endtask

   initial begin
      logic [N-1:0] mask;
      logic [W-1:0] wd;
      clr_n = 1'b1;
      randomize_inputs();
      #2 clr_n = 1'b0;
      #1 cmp_on = 1'b1;
      check_all_zero("reset");
      for (int c = 0; c < 3; c++) begin
         randomize_inputs();
         step();
      end
      check_all_zero("reset_hold");
      idle();
      clr_n = 1'b1;
      step();

      // 1-to-1 sweep
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            wd = i[0] ? 64'hdeadbeefdeadbeef : 64'hbeefdeadbeefdead;
            send_en[i] = 1'b1; send_to[i] = N'(1) << j;
            send_addr[i] = BADDR'(i + j + 1); send_word[i] = wd;
            step();
            idle();
            check($sformatf("sweep %0d->%0d recv_en", i, j), 64'(recv_en), 64'(N'(1) << j));
            check($sformatf("sweep %0d->%0d addr", i, j), 64'(recv_addr[j]), 64'(i + j + 1));
            check($sformatf("sweep %0d->%0d word", i, j), recv_word[j], wd);
            check($sformatf("sweep %0d->%0d from", i, j), 64'(recv_from[j]), 64'(1 << i));
         end
      end

      // broadcast / multicast with wrap-around
      for (int m = 2; m <= 3; m++) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               mask = '0;
               for (int k = 0; k < m; k++) mask[(j + k) % N] = 1'b1;
               wd = {32'(i * 16 + j), 32'(m)} ^ 64'h0123_4567_89ab_cdef;
               send_en[i] = 1'b1; send_to[i] = mask;
               send_addr[i] = BADDR'(100 * m + 10 * i + j); send_word[i] = wd;
               step();
               idle();
               check($sformatf("bcast%0d %0d/%0d recv_en", m, i, j), 64'(recv_en), 64'(mask));
               for (int k = 0; k < N; k++) begin
                  if (mask[k]) begin
                     check($sformatf("bcast%0d %0d rx%0d addr", m, i, k), 64'(recv_addr[k]), 64'(100 * m + 10 * i + j));
                     check($sformatf("bcast%0d %0d rx%0d word", m, i, k), recv_word[k], wd);
                     check($sformatf("bcast%0d %0d rx%0d from", m, i, k), 64'(recv_from[k]), 64'(1 << i));
                  end
               end
            end
         end
      end

      // collision: senders 2 and 5 to receiver 3
      send_en[2] = 1'b1; send_to[2] = 8'b0000_1000; send_addr[2] = 15'h10; send_word[2] = 64'h22;
      send_en[5] = 1'b1; send_to[5] = 8'b0000_1000; send_addr[5] = 15'h20; send_word[5] = 64'h55;
      step();
      idle();
      check("collision recv_en", 64'(recv_en), 64'h08);
      check("collision addr", 64'(recv_addr[3]), HIGH_FIRST ? 64'h20 : 64'h10);
      check("collision from", 64'(recv_from[3]), HIGH_FIRST ? 64'h20 : 64'h04);
      check("collision word", recv_word[3], HIGH_FIRST ? 64'h55 : 64'h22);

      // partial multicast collision
      send_en[0] = 1'b1; send_to[0] = 8'b0000_0010; send_addr[0] = 15'h100; send_word[0] = 64'hAAAA;
      send_en[4] = 1'b1; send_to[4] = 8'b0100_0010; send_addr[4] = 15'h200; send_word[4] = 64'hBBBB;
      step();
      idle();
      check("partial recv_en", 64'(recv_en), 64'h42);
      check("partial rx1 word", recv_word[1], HIGH_FIRST ? 64'hBBBB : 64'hAAAA);
      check("partial rx1 from", 64'(recv_from[1]), HIGH_FIRST ? 64'h10 : 64'h01);
      check("partial rx6 word", recv_word[6], 64'hBBBB);
      check("partial rx6 addr", 64'(recv_addr[6]), 64'h200);
      check("partial rx6 from", 64'(recv_from[6]), 64'h10);

      // strobe held 3 cycles, then hold of addr/word
      send_en[6] = 1'b1; send_to[6] = 8'b0000_0100; send_addr[6] = 15'h55;
      for (int c = 0; c < 3; c++) begin
         send_word[6] = 64'(c + 1) * 64'h1111;
         step();
         check($sformatf("strobe cycle %0d recv_en", c), 64'(recv_en), 64'h04);
         check($sformatf("strobe cycle %0d word", c), recv_word[2], 64'(c + 1) * 64'h1111);
      end
      idle();
      step();
      check("hold recv_en", 64'(recv_en), 64'h00);
      check("hold from", 64'(recv_from[2]), 64'h00);
      check("hold addr", 64'(recv_addr[2]), 64'h55);
      check("hold word", recv_word[2], 64'h3333);

      // randomized traffic, with an asynchronous reset dropped mid-transfer
      for (int c = 0; c < 1500; c++) begin
         randomize_inputs();
         step();
         if (c == 700) begin
            send_en = '1;
            for (int i = 0; i < N; i++) send_to[i] = 8'hFF;
            step();
            check("pre-async recv_en", 64'(recv_en), 64'hFF);
            #2 clr_n = 1'b0;
            #1;
            check_all_zero("async");
            step();
            clr_n = 1'b1;
         end
      end
      idle();
      step();
      step();
      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/interconn_priority.md
Name: interconn_priority

Overview:
- N-port registered crossbar between MVUs. Each sender i drives a one-hot or multi-hot destination mask, a memory address and a data word.
- Each receiver gets at most one word per cycle. Collisions are resolved by fixed priority: the lowest sender index wins.
- Supports 1-to-1, broadcast/multicast (multiple destination bits set) and self-send (i to i).
- Sits between MVU output write ports and MVU memory write ports.

Parameters:
- N, 8, number of MVUs (sender/receiver ports).
- W, 64, data word width in bits.
- BADDR, 15, memory address width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr_n  input  1  asynchronous active-low reset.
- send_to  input  [N-1:0] x N (unpacked array)  send_to[i] bit j set means sender i targets receiver j.
- send_en  input  1 x N  sender i request valid.
- send_addr  input  [BADDR-1:0] x N  destination memory address from sender i.
- send_word  input  [W-1:0] x N  data word from sender i.
- recv_from  output  [N-1:0] x N  one-hot index of the sender whose word receiver j accepted; 0 when idle.
- recv_en  output  1 x N  receiver j write strobe.
- recv_addr  output  [BADDR-1:0] x N  address delivered to receiver j.
- recv_word  output  [W-1:0] x N  word delivered to receiver j.

Behaviour:
- Reset (clr_n=0, asynchronous): every recv_en=0, recv_from=0, recv_addr=0, recv_word=0 for all N receivers. Reset has priority over everything and drops any in-flight transfer.
- Request definition: req[j][i] = send_en[i] & send_to[i][j].
- Arbitration, per receiver j, combinational: winner = lowest i with req[j][i]=1. Grant vector is one-hot.
- Registered outputs, one-cycle latency. On the rising edge where a request is sampled:
  - recv_en[j] <= |req[j]
  - recv_from[j] <= grant vector
  - recv_addr[j] <= send_addr[winner]
  - recv_word[j] <= send_word[winner]
- recv_en is a one-cycle pulse per sampled request. A sender holding send_en for k cycles produces k consecutive deliveries.
- Idle receiver (no requests): recv_en=0, recv_from=0; recv_addr and recv_word hold their last value.
- Multicast: a sender's mask with several bits set delivers the identical addr/word to every targeted receiver in the same cycle. Each receiver arbitrates independently, so a sender may win at some receivers and lose at others.
- Losing requests are dropped silently. There is no backpressure or grant return; upstream must avoid collisions or accept loss.
- send_to bits with send_en=0 are ignored. send_en=1 with send_to=0 produces no delivery.
- Self-send (bit i set in send_to[i]) is legal and is treated like any other destination.
- Implementation:
  - Per-receiver priority encoder (for loop over i, first hit wins) plus N-wide one-hot mux.
  - No multicycle paths. No internal state other than the output registers.

Optional Feature:
- Macro: INTERCONN_PRIORITY_HIGH_FIRST_EN.
- Defined: arbitration reverses; the highest sender index with a request wins at each receiver. recv_from and the addr/word mux follow that winner.
- Undefined (default): the lowest sender index wins, as described above.
- All other behaviour, latency and reset values are identical in both builds.

Test Plan:
- Reset: hold clr_n=0 with random send_* values -> all recv_en=0, recv_from=0, recv_addr=0, recv_word=0. Assert clr_n=0 mid-transfer -> outputs clear immediately, without waiting for a clock edge.
- 1-to-1 sweep: for every i,j in 0..7, sender i sends addr=i+j+1 with word 64'hdeadbeefdeadbeef (i odd) or 64'hbeefdeadbeefdead (i even), one-cycle send_en pulse to j. One cycle later: recv_en[j]=1, recv_addr[j]=i+j+1, recv_word[j]=the sent word, recv_from[j]=1<<i. All other receivers idle.
- Broadcast: sender i targets {j,(j+1)%8}, then {j,(j+1)%8,(j+2)%8}, for all i,j. Every targeted receiver shows the same addr/word with recv_from=1<<i, including the wrap-around at j=7.
- Collision: senders 2 and 5 both target receiver 3 in the same cycle (addr 0x10 vs 0x20) -> recv_addr[3]=0x10, recv_from[3]=8'b00000100. With INTERCONN_PRIORITY_HIGH_FIRST_EN defined -> recv_addr[3]=0x20, recv_from[3]=8'b00100000.
- Partial multicast collision: sender 0 targets receiver 1; sender 4 targets receivers 1 and 6 -> receiver 1 gets sender 0's word, receiver 6 gets sender 4's word, same cycle.
- Strobe and hold: send_en held 3 cycles -> recv_en high 3 consecutive cycles. After release, recv_en=0 and recv_from=0, while recv_addr/recv_word hold their last value.
